// File: rtl/iosys_romstream_if.sv
// ---------------------------------------------------------------------------
// iosys_romstream_if
// Bundles the softcore register-bus side (ROM-load ctrl/data/status) and the
// ROM-loader byte stream side of iosys_romstream.
//   reg_ctrl_we   : ctrl register write strobe            (master -> slave)
//   reg_data_we   : data register write strobe            (master -> slave)
//   reg_di        : register write data, 32 bits          (master -> slave)
//   rom_ready     : loader can take the next byte         (master -> slave)
//   reg_data_wait : data write not accepted, CPU holds    (slave -> master)
//   reg_status_do : status word                           (slave -> master)
//   byte_count    : bytes emitted since last start        (slave -> master)
//   rom_loading   : load in progress                      (slave -> master)
//   rom_do        : byte data                             (slave -> master)
//   rom_do_valid  : byte strobe                           (slave -> master)
// ---------------------------------------------------------------------------
interface iosys_romstream_if;
   logic        reg_ctrl_we;
   logic        reg_data_we;
   logic [31:0] reg_di;
   logic        reg_data_wait;
   logic [31:0] reg_status_do;
   logic [31:0] byte_count;
   logic        rom_loading;
   logic [7:0]  rom_do;
   logic        rom_do_valid;
   logic        rom_ready;

   modport master (
      output reg_ctrl_we, reg_data_we, reg_di, rom_ready,
      input  reg_data_wait, reg_status_do, byte_count, rom_loading,
             rom_do, rom_do_valid
   );

   modport slave (
      input  reg_ctrl_we, reg_data_we, reg_di, rom_ready,
      output reg_data_wait, reg_status_do, byte_count, rom_loading,
             rom_do, rom_do_valid
   );
endinterface

// File: rtl/iosys_romstream.sv
// ---------------------------------------------------------------------------
// iosys_romstream
// Word FIFO plus byte serialiser feeding the core's ROM loader. The CPU starts
// a load through the ctrl register, pushes WORD_BYTES-byte words through the
// data register (stalled by reg_data_wait when the FIFO is full) and requests
// finish; rom_loading stays high until everything queued has been emitted.
// Bytes go out LSB first, each strobed for VALID_CYCLES cycles followed by
// GAP_CYCLES idle cycles, and only start while rom_ready is high.
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : iosys_romstream_if.slave (register bus + ROM byte stream)
// ---------------------------------------------------------------------------
module iosys_romstream #(
   parameter int FIFO_DEPTH   = 8,
   parameter int WORD_BYTES   = 4,
   parameter int VALID_CYCLES = 2,
   parameter int GAP_CYCLES   = 2
) (
   input  logic               clk,
   input  logic               resetn,
   iosys_romstream_if.slave   bus
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int WW = 8 * WORD_BYTES;

   typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_GAP} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_timer;
   logic [3:0]    w_timer_nxt;

   logic [WW-1:0] r_fifo [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic [WW-1:0] r_word;
   logic [2:0]    r_bytes_left;

   logic          r_loading;
   logic          r_finish_pending;
   logic          r_rom_do_valid;
   logic [7:0]    r_rom_do;
   logic [31:0]   r_byte_count;

   logic          w_start;
   logic          w_finish_req;
   logic          w_full;
   logic          w_empty;
   logic          w_data_en;
   logic          w_push;
   logic          w_byte_avail;
   logic          w_launch;
   logic          w_strobe_end;
   logic          w_pop;
   logic          w_done;
   logic          w_busy;
   logic [WW-1:0] w_head;
   logic          w_unused_di;

   assign w_start      = bus.reg_ctrl_we && (bus.reg_di[7:0] == 8'd1);
   assign w_finish_req = bus.reg_ctrl_we && (bus.reg_di[7:0] == 8'd0) && r_loading;

   // Full/empty come from the registered count only, so a pop in this cycle
   // never makes room for a push in the same cycle.
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);

   // A ctrl write in the same cycle always wins over the data write.
   assign w_data_en         = bus.reg_data_we && !bus.reg_ctrl_we && r_loading && !r_finish_pending;
   assign w_push            = w_data_en && !w_full;
   assign bus.reg_data_wait = w_data_en && w_full;

   // An incoming word can be launched straight away when the FIFO is empty,
   // giving the first strobe one cycle after the write.
   assign w_byte_avail = (r_bytes_left != 3'd0) || !w_empty || w_push;
   assign w_head       = w_empty ? bus.reg_di[WW-1:0] : r_fifo[r_rd_ptr];
   assign w_pop        = w_launch && (r_bytes_left == 3'd0);

   assign w_done = r_finish_pending && w_empty && (r_state == ST_IDLE) && (r_bytes_left == 3'd0);
   assign w_busy = (r_state != ST_IDLE) || (r_bytes_left != 3'd0);

   assign w_unused_di = ^bus.reg_di;

   // Serialiser next state. The last GAP cycle (or last STROBE cycle when
   // there is no gap) behaves like IDLE so the byte period is exactly
   // VALID_CYCLES + GAP_CYCLES.
   always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = r_timer;
      w_launch     = 1'b0;
      w_strobe_end = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_launch = bus.rom_ready && w_byte_avail;
         end
         ST_STROBE: begin
            if (r_timer == 4'd0) begin
               w_strobe_end = 1'b1;
               if (GAP_CYCLES == 0) begin
                  w_state_nxt = ST_IDLE;
                  w_launch    = bus.rom_ready && w_byte_avail;
               end else begin
                  w_state_nxt = ST_GAP;
                  w_timer_nxt = 4'(GAP_CYCLES - 1);
               end
            end else begin
               w_timer_nxt = r_timer - 4'd1;
            end
         end
         ST_GAP: begin
            if (r_timer == 4'd0) begin
               w_state_nxt = ST_IDLE;
               w_launch    = bus.rom_ready && w_byte_avail;
            end else begin
               w_timer_nxt = r_timer - 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (w_launch) begin
         w_state_nxt = ST_STROBE;
         w_timer_nxt = 4'(VALID_CYCLES - 1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_timer <= 4'd0;
      end else if (w_start) begin
         r_state <= ST_IDLE;
         r_timer <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_loading        <= 1'b0;
         r_finish_pending <= 1'b0;
         r_rom_do_valid   <= 1'b0;
         r_rom_do         <= 8'd0;
         r_byte_count     <= 32'd0;
         r_wr_ptr         <= '0;
         r_rd_ptr         <= '0;
         r_count          <= '0;
         r_bytes_left     <= 3'd0;
      end else if (w_start) begin
         // Fresh start, also when already loading: flush everything queued.
         r_loading        <= 1'b1;
         r_finish_pending <= 1'b0;
         r_rom_do_valid   <= 1'b0;
         r_byte_count     <= 32'd0;
         r_wr_ptr         <= '0;
         r_rd_ptr         <= '0;
         r_count          <= '0;
         r_bytes_left     <= 3'd0;
      end else begin
         if (w_finish_req) begin
            r_finish_pending <= 1'b1;
         end
         if (w_done) begin
            r_loading        <= 1'b0;
            r_finish_pending <= 1'b0;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_launch) begin
            r_rom_do_valid <= 1'b1;
            if (r_bytes_left != 3'd0) begin
               r_rom_do     <= r_word[7:0];
               r_bytes_left <= r_bytes_left - 3'd1;
            end else begin
               r_rom_do     <= w_head[7:0];
               r_bytes_left <= 3'(WORD_BYTES - 1);
            end
         end else if (w_strobe_end) begin
            r_rom_do_valid <= 1'b0;
         end
         if (w_strobe_end) begin
            r_byte_count <= r_byte_count + 32'd1;
         end
      end
   end

   // Word storage holds no control state and needs no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= bus.reg_di[WW-1:0];
      end
      if (w_launch) begin
         r_word <= (r_bytes_left != 3'd0) ? (r_word >> 8) : (w_head >> 8);
      end
   end

   assign bus.rom_loading   = r_loading;
   assign bus.rom_do        = r_rom_do;
   assign bus.rom_do_valid  = r_rom_do_valid;
   assign bus.byte_count    = r_byte_count;
   assign bus.reg_status_do = {16'd0, 8'(r_count), 3'd0, r_finish_pending,
                               w_busy, w_empty, w_full, r_loading};

endmodule

// File: tb/tb_iosys_romstream.sv
// ---------------------------------------------------------------------------
// tb_iosys_romstream
// Scoreboard bench for iosys_romstream. dut_a uses the default parameters and
// is checked by a byte monitor against a queue of expected bytes; dut_b uses
// WORD_BYTES=2, VALID_CYCLES=1, GAP_CYCLES=0 for the narrow-word case.
// ---------------------------------------------------------------------------
module tb_iosys_romstream;
   localparam int DEPTH = 8;
   localparam int VC    = 2;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   iosys_romstream_if ifa ();
   iosys_romstream_if ifb ();

   iosys_romstream #(.FIFO_DEPTH(DEPTH), .WORD_BYTES(4), .VALID_CYCLES(VC), .GAP_CYCLES(2))
      dut_a (.clk(clk), .resetn(resetn), .bus(ifa.slave));
   iosys_romstream #(.FIFO_DEPTH(4), .WORD_BYTES(2), .VALID_CYCLES(1), .GAP_CYCLES(0))
      dut_b (.clk(clk), .resetn(resetn), .bus(ifb.slave));

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   bit abort_mon  = 1'b0;
   bit rnd_ready  = 1'b0;
   bit m_loading  = 1'b0;
   bit m_pending  = 1'b0;
   int m_bytes    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s t=%0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Byte monitor: a new byte starts when valid rises or a full strobe has
   // already been seen; every strobe must last exactly VC cycles.
   initial begin : monitor
      bit prev = 1'b0;
      int run = 0;
      logic [7:0] cur = 8'd0;
      forever begin
         @(negedge clk);
         if (abort_mon) begin
            abort_mon = 1'b0;
            prev = 1'b0;
            run = 0;
         end else begin
            if (ifa.rom_do_valid === 1'b1) begin
               if (!prev || run == VC) begin
                  if (exp_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_byte actual=%h required=none t=%0t", ifa.rom_do, $time);
                  end else begin
                     chk("byte", {24'd0, ifa.rom_do}, {24'd0, exp_q.pop_front()});
                  end
                  cur = ifa.rom_do;
                  run = 1;
               end else begin
                  run++;
                  chk("byte_hold", {24'd0, ifa.rom_do}, {24'd0, cur});
               end
            end else if (prev) begin
               chk("strobe_len", run, VC);
            end
            prev = (ifa.rom_do_valid === 1'b1);
         end
      end
   end

   initial begin : ready_rand
      forever begin
         @(posedge clk);
         #1;
         if (rnd_ready) ifa.rom_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic ctrl(input logic [7:0] v);
      ifa.reg_ctrl_we = 1'b1;
      ifa.reg_di      = {24'd0, v};
      tick();
      ifa.reg_ctrl_we = 1'b0;
      if (v == 8'd1) begin
         m_loading = 1'b1;
         m_pending = 1'b0;
         m_bytes   = 0;
         exp_q.delete();
      end else if (v == 8'd0 && m_loading) begin
         m_pending = 1'b1;
      end
   endtask

   task automatic wr(input logic [31:0] d);
      bit acc;
      int n;
      acc = m_loading && !m_pending;
      n = 0;
      ifa.reg_data_we = 1'b1;
      ifa.reg_di      = d;
      @(negedge clk);
      while (ifa.reg_data_wait === 1'b1 && n < 300) begin
         tick();
         @(negedge clk);
         n++;
      end
      if (n >= 300) fail_now("wr_timeout");
      else if (!acc) chk("drop_wait", {31'd0, ifa.reg_data_wait}, 32'd0);
      else begin
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back(d[8*b +: 8]);
            m_bytes++;
         end
      end
      @(posedge clk);
      #1;
      ifa.reg_data_we = 1'b0;
   endtask

   task automatic wait_drained(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!(exp_q.size() == 0 && ifa.rom_do_valid === 1'b0 && ifa.reg_status_do[3] === 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_now(name);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog_timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] w9;
      int n;
      resetn = 1'b0;
      ifa.reg_ctrl_we = 1'b0; ifa.reg_data_we = 1'b0; ifa.reg_di = 32'd0; ifa.rom_ready = 1'b0;
      ifb.reg_ctrl_we = 1'b0; ifb.reg_data_we = 1'b0; ifb.reg_di = 32'd0; ifb.rom_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_loading", {31'd0, ifa.rom_loading}, 32'd0);
      chk("rst_valid",   {31'd0, ifa.rom_do_valid}, 32'd0);
      chk("rst_do",      {24'd0, ifa.rom_do}, 32'd0);
      chk("rst_count",   ifa.byte_count, 32'd0);
      chk("rst_status",  ifa.reg_status_do, 32'h4);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      tick();

      // Defaults: exact strobe/gap timing for one word.
      ctrl(8'd1);
      chk("start_status", ifa.reg_status_do, 32'h5);
      ifa.rom_ready   = 1'b1;
      ifa.reg_data_we = 1'b1;
      ifa.reg_di      = 32'h44332211;
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back(8'(8'h11 * (b + 1)));
         m_bytes++;
      end
      tick();
      ifa.reg_data_we = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         chk("t1_valid", {31'd0, ifa.rom_do_valid}, {31'd0, (((c - 1) % 4) < 2)});
         if (((c - 1) % 4) < 2) chk("t1_do", {24'd0, ifa.rom_do}, 32'h11 * (((c - 1) / 4) + 1));
      end
      chk("t1_count", ifa.byte_count, 32'd4);
      @(posedge clk);
      #1;

      // Backpressure: fill the FIFO with the loader stalled.
      ctrl(8'd1);
      ifa.rom_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) wr($urandom);
      w9 = $urandom;
      ifa.reg_data_we = 1'b1;
      ifa.reg_di      = w9;
      @(negedge clk);
      chk("t2_wait_full", {31'd0, ifa.reg_data_wait}, 32'd1);
      chk("t2_full_flag", {31'd0, ifa.reg_status_do[1]}, 32'd1);
      chk("t2_fill",      {24'd0, ifa.reg_status_do[15:8]}, DEPTH);
      tick();
      ifa.rom_ready = 1'b1;
      @(negedge clk);
      chk("t2_wait_popcycle", {31'd0, ifa.reg_data_wait}, 32'd1);
      tick();
      @(negedge clk);
      chk("t2_wait_after_pop", {31'd0, ifa.reg_data_wait}, 32'd0);
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back(w9[8*b +: 8]);
         m_bytes++;
      end
      @(posedge clk);
      #1;
      ifa.reg_data_we = 1'b0;
      wait_drained("t2_drain_timeout");
      chk("t2_count", ifa.byte_count, m_bytes);

      // Drain-before-finish.
      ctrl(8'd1);
      wr(32'h0403_0201);
      wr(32'h0807_0605);
      ctrl(8'd0);
      chk("t3_pending", {31'd0, ifa.reg_status_do[4]}, 32'd1);
      wr(32'hDEAD_BEEF);
      n = 0;
      @(negedge clk);
      while (ifa.rom_loading === 1'b1 && n < 300) begin
         @(negedge clk);
         if (ifa.rom_do_valid === 1'b1 && ifa.rom_loading !== 1'b1) fail_now("t3_early_drop");
         n++;
      end
      chk("t3_loading_low", {31'd0, ifa.rom_loading}, 32'd0);
      chk("t3_all_sent",    exp_q.size(), 32'd0);
      chk("t3_count",       ifa.byte_count, 32'd8);
      chk("t3_status",      ifa.reg_status_do, 32'h4);
      m_loading = 1'b0;
      m_pending = 1'b0;
      @(posedge clk);
      #1;

      // Restart while byte 0x22 is strobing.
      ctrl(8'd1);
      wr(32'h44332211);
      wr(32'hA5A5A5A5);
      n = 0;
      @(negedge clk);
      while (!(ifa.rom_do_valid === 1'b1 && ifa.rom_do === 8'h22) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail_now("t4_no_0x22");
      @(posedge clk);
      #1;
      abort_mon = 1'b1;
      ctrl(8'd1);
      @(negedge clk);
      chk("t4_valid",   {31'd0, ifa.rom_do_valid}, 32'd0);
      chk("t4_status",  ifa.reg_status_do, 32'h5);
      chk("t4_count",   ifa.byte_count, 32'd0);
      chk("t4_loading", {31'd0, ifa.rom_loading}, 32'd1);
      @(posedge clk);
      #1;
      repeat (12) tick();

      // Narrow words, single-cycle strobes, no gap.
      ifb.reg_ctrl_we = 1'b1;
      ifb.reg_di      = 32'd1;
      tick();
      ifb.reg_ctrl_we = 1'b0;
      ifb.rom_ready   = 1'b1;
      ifb.reg_data_we = 1'b1;
      ifb.reg_di      = 32'h1234BEEF;
      tick();
      ifb.reg_data_we = 1'b0;
      @(negedge clk);
      chk("t5_valid0", {31'd0, ifb.rom_do_valid}, 32'd1);
      chk("t5_do0",    {24'd0, ifb.rom_do}, 32'hEF);
      tick();
      @(negedge clk);
      chk("t5_valid1", {31'd0, ifb.rom_do_valid}, 32'd1);
      chk("t5_do1",    {24'd0, ifb.rom_do}, 32'hBE);
      tick();
      @(negedge clk);
      chk("t5_valid2", {31'd0, ifb.rom_do_valid}, 32'd0);
      chk("t5_count",  ifb.byte_count, 32'd2);
      @(posedge clk);
      #1;

      // Randomised stream with random loader backpressure.
      ctrl(8'd1);
      rnd_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 5)) tick();
         if ($urandom_range(0, 9) == 0) ctrl(8'($urandom_range(2, 255)));
         wr($urandom);
      end
      rnd_ready = 1'b0;
      tick();
      ifa.rom_ready = 1'b1;
      ctrl(8'd0);
      n = 0;
      @(negedge clk);
      while (ifa.rom_loading === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("rnd_loading_low", {31'd0, ifa.rom_loading}, 32'd0);
      chk("rnd_all_sent",    exp_q.size(), 32'd0);
      chk("rnd_count",       ifa.byte_count, m_bytes);
      m_loading = 1'b0;
      m_pending = 1'b0;
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a strobe.
      ctrl(8'd1);
      wr(32'h0D0C0B0A);
      n = 0;
      @(negedge clk);
      while (ifa.rom_do_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) fail_now("t6_no_strobe");
      #2;
      abort_mon = 1'b1;
      resetn    = 1'b0;
      #1;
      chk("t6_loading", {31'd0, ifa.rom_loading}, 32'd0);
      chk("t6_valid",   {31'd0, ifa.rom_do_valid}, 32'd0);
      chk("t6_do",      {24'd0, ifa.rom_do}, 32'd0);
      chk("t6_count",   ifa.byte_count, 32'd0);
      chk("t6_status",  ifa.reg_status_do, 32'h4);
      exp_q.delete();
      m_loading = 1'b0;
      m_pending = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      tick();
      wr(32'h12345678);
      repeat (10) tick();
      chk("t6_nothing_sent", ifa.byte_count, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
